// File: rtl/decode_issue_if.sv
// Fetch-side, write-back and issue-side signals of decode_issue grouped as one bundle.
// slave is the decode/issue block; master is whatever drives fetch, write-back and execute.
interface decode_issue_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [31:0]     in_instr;
    logic            flush;
    logic            wb_we;
    logic [4:0]      wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_instr;
    logic [XLEN-1:0] out_rs1_data;
    logic [XLEN-1:0] out_rs2_data;
    logic [4:0]      out_rd;
    logic            out_rd_we;
    logic            out_is_load;
    logic [31:0]     stall_cnt;

    modport master (
        output in_valid, in_pc, in_instr, flush, wb_we, wb_addr, wb_data, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, out_rs1_data, out_rs2_data,
               out_rd, out_rd_we, out_is_load, stall_cnt
    );

    modport slave (
        input  in_valid, in_pc, in_instr, flush, wb_we, wb_addr, wb_data, out_ready,
        output in_ready, out_valid, out_pc, out_instr, out_rs1_data, out_rs2_data,
               out_rd, out_rd_we, out_is_load, stall_cnt
    );
endinterface

// File: rtl/decode_issue.sv
// RV32I decode/issue stage: small instruction FIFO, load-latency scoreboard,
// register file with write-through read, and a single issue register.
module decode_issue #(
    parameter int XLEN     = 32,
    parameter int LOAD_LAT = 2,
    parameter int IQ_DEPTH = 2
) (
    input logic           clk,
    input logic           reset,
    decode_issue_if.slave bus
);
    localparam int AW = $clog2(IQ_DEPTH);
    localparam int CW = $clog2(LOAD_LAT + 1);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } iq_entry_t;

    iq_entry_t               iq [IQ_DEPTH];
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic [AW:0]             count;
    logic [31:0][CW-1:0]     sb;
    logic [XLEN-1:0]         rf [32];
    logic [31:0]             stall_q;

    logic                    full, empty, enq, issue, hazard;
    iq_entry_t               head;
    logic [6:0]              opcode;
    logic [4:0]              rs1, rs2, rd;
    logic                    use_rs1, use_rs2, writes_rd, is_load;
    logic [XLEN-1:0]         rs1_data, rs2_data;

    assign full  = (count == (AW+1)'(IQ_DEPTH));
    assign empty = (count == '0);
    assign bus.in_ready  = ~full;
    assign bus.stall_cnt = stall_q;

    assign head   = iq[rd_ptr];
    assign opcode = head.instr[6:0];
    assign rs1    = head.instr[19:15];
    assign rs2    = head.instr[24:20];
    assign rd     = head.instr[11:7];

    always_comb begin
        use_rs1   = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
        use_rs2   = (opcode == OP_REG || opcode == OP_STORE || opcode == OP_BRANCH);
        writes_rd = (opcode == OP_REG || opcode == OP_IMM || opcode == OP_LOAD ||
                     opcode == OP_JAL || opcode == OP_JALR || opcode == OP_LUI ||
                     opcode == OP_AUIPC);
        is_load   = (opcode == OP_LOAD);
    end

    // sb[0] is never loaded, so x0 can never raise a hazard.
    assign hazard = (use_rs1 && sb[rs1] != '0) || (use_rs2 && sb[rs2] != '0);
    assign issue  = !empty && !hazard && (!bus.out_valid || bus.out_ready) && !bus.flush;
    assign enq    = bus.in_valid && !full && !bus.flush;

    // Write-through so an operand written back this cycle is captured at issue.
    always_comb begin
        rs1_data = rf[rs1];
        rs2_data = rf[rs2];
        if (bus.wb_we && bus.wb_addr == rs1) rs1_data = bus.wb_data;
        if (bus.wb_we && bus.wb_addr == rs2) rs2_data = bus.wb_data;
        if (rs1 == '0) rs1_data = '0;
        if (rs2 == '0) rs2_data = '0;
    end

    always_ff @(posedge clk) begin
        if (enq) iq[wr_ptr] <= '{pc: bus.in_pc, instr: bus.in_instr};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq)   wr_ptr <= wr_ptr + 1'b1;
            if (issue) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(enq) - (AW+1)'(issue);
        end
    end

    // Counters tick down every cycle; a load issue re-arms its rd over the decrement.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sb <= '0;
        end else if (bus.flush) begin
            sb <= '0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (issue && is_load && rd == 5'(i)) sb[i] <= CW'(LOAD_LAT);
                else if (sb[i] != '0)                sb[i] <= sb[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (bus.wb_we && bus.wb_addr != '0) rf[bus.wb_addr] <= bus.wb_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.out_valid    <= 1'b0;
            bus.out_pc       <= '0;
            bus.out_instr    <= '0;
            bus.out_rs1_data <= '0;
            bus.out_rs2_data <= '0;
            bus.out_rd       <= '0;
            bus.out_rd_we    <= 1'b0;
            bus.out_is_load  <= 1'b0;
        end else if (bus.flush) begin
            bus.out_valid <= 1'b0;
        end else if (issue) begin
            bus.out_valid    <= 1'b1;
            bus.out_pc       <= head.pc;
            bus.out_instr    <= head.instr;
            bus.out_rs1_data <= rs1_data;
            bus.out_rs2_data <= rs2_data;
            bus.out_rd       <= rd;
            bus.out_rd_we    <= writes_rd && rd != '0;
            bus.out_is_load  <= is_load;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

    // Only scoreboard blocking counts; plain execute back-pressure does not.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                               stall_q <= '0;
        else if (!empty && hazard && stall_q != '1) stall_q <= stall_q + 1'b1;
    end
endmodule

// File: tb/tb_decode_issue.sv
// Random + directed bench for decode_issue against a queue/timestamp model of the issue rules.
module tb_decode_issue;
    localparam int XLEN = 32;
    localparam int LL   = 2;
    localparam int D    = 2;

    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_BR = 7'b1100011, OP_LD = 7'b0000011,
                           OP_ST = 7'b0100011, OP_IMM = 7'b0010011, OP_R = 7'b0110011,
                           OP_SYS = 7'b1110011;

    localparam logic [31:0] I_ADDI1 = 32'h0050_0093; // addi x1,x0,5
    localparam logic [31:0] I_LW5   = 32'h0000_2283; // lw   x5,0(x0)
    localparam logic [31:0] I_ADD6  = 32'h0052_8333; // add  x6,x5,x5
    localparam logic [31:0] I_ADD8  = 32'h0003_8433; // add  x8,x7,x0
    localparam logic [31:0] I_ADD9  = 32'h0000_04B3; // add  x9,x0,x0
    localparam logic [31:0] I_LW3   = 32'h0000_2183; // lw   x3,0(x0)
    localparam logic [31:0] I_SUB4  = 32'h4031_8233; // sub  x4,x3,x3

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    decode_issue_if #(.XLEN(XLEN)) bus ();
    decode_issue #(.XLEN(XLEN), .LOAD_LAT(LL), .IQ_DEPTH(D)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } ent_t;

    ent_t            mq[$];
    longint          free_at [32];   // first cycle in which the register is no longer busy
    longint          cyc;
    logic [XLEN-1:0] m_rf [32];
    bit              m_known [32];
    logic            m_ov, m_rdwe, m_ld;
    logic [XLEN-1:0] m_pc, m_rs1, m_rs2;
    bit              m_k1, m_k2;
    logic [31:0]     m_instr;
    logic [4:0]      m_rd;
    logic [31:0]     m_stall;

    function automatic logic [XLEN-1:0] mread(input logic [4:0] a);
        if (a == 0) return '0;
        if (bus.wb_we && bus.wb_addr == a) return bus.wb_data;
        return m_rf[a];
    endfunction

    function automatic bit mknown(input logic [4:0] a);
        return a == 0 || (bus.wb_we && bus.wb_addr == a) || m_known[a];
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            foreach (free_at[i]) free_at[i] = 0;
            cyc = 0; m_ov = 0; m_pc = '0; m_instr = '0; m_rs1 = '0; m_rs2 = '0;
            m_rd = '0; m_rdwe = 0; m_ld = 0; m_stall = '0; m_k1 = 1; m_k2 = 1;
        end else begin
            bit haz, iss, full;
            logic [6:0] op;
            logic [4:0] r1, r2, rd;
            ent_t h;
            bit u1, u2, wr;
            full = (mq.size() == D);
            haz = 0; u1 = 0; u2 = 0; wr = 0; op = '0; r1 = '0; r2 = '0; rd = '0;
            h.pc = '0; h.instr = '0;
            if (mq.size() > 0) begin
                h  = mq[0];
                op = h.instr[6:0]; r1 = h.instr[19:15]; r2 = h.instr[24:20]; rd = h.instr[11:7];
                u1 = !(op inside {OP_LUI, OP_AUIPC, OP_JAL});
                u2 = op inside {OP_R, OP_ST, OP_BR};
                wr = op inside {OP_R, OP_IMM, OP_LD, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
                haz = (u1 && r1 != 0 && cyc < free_at[r1]) || (u2 && r2 != 0 && cyc < free_at[r2]);
                if (haz && m_stall != 32'hFFFF_FFFF) m_stall++;
            end
            iss = mq.size() > 0 && !haz && (!m_ov || bus.out_ready) && !bus.flush;
            if (bus.flush) begin
                mq.delete();
                m_ov = 0;
                foreach (free_at[i]) free_at[i] = 0;
            end else begin
                if (iss) begin
                    void'(mq.pop_front());
                    m_ov = 1; m_pc = h.pc; m_instr = h.instr;
                    m_rs1 = mread(r1); m_rs2 = mread(r2); m_k1 = mknown(r1); m_k2 = mknown(r2);
                    m_rd = rd; m_rdwe = wr && rd != 0; m_ld = (op == OP_LD);
                    if (op == OP_LD && rd != 0) free_at[rd] = cyc + LL + 1;
                end else if (bus.out_ready) begin
                    m_ov = 0;
                end
                if (bus.in_valid && !full) mq.push_back('{pc: bus.in_pc, instr: bus.in_instr});
            end
            if (bus.wb_we && bus.wb_addr != 0) begin
                m_rf[bus.wb_addr] = bus.wb_data;
                m_known[bus.wb_addr] = 1;
            end
            cyc++;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!reset) begin
            chk("in_ready", bus.in_ready, mq.size() < D);
            chk("out_valid", bus.out_valid, m_ov);
            chk("stall_cnt", bus.stall_cnt, m_stall);
            if (m_ov) begin
                chk("out_pc", bus.out_pc, m_pc);
                chk("out_instr", bus.out_instr, m_instr);
                chk("out_rd", bus.out_rd, m_rd);
                chk("out_rd_we", bus.out_rd_we, m_rdwe);
                chk("out_is_load", bus.out_is_load, m_ld);
                if (m_k1) chk("out_rs1_data", bus.out_rs1_data, m_rs1);
                if (m_k2) chk("out_rs2_data", bus.out_rs2_data, m_rs2);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic enq(input logic [XLEN-1:0] pc, input logic [31:0] ins);
        bus.in_valid = 1'b1; bus.in_pc = pc; bus.in_instr = ins;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 0; bus.flush = 0; bus.wb_we = 0; bus.out_ready = 1;
        repeat (n) tick();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [10];
        logic [31:0] w;
        ops = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BR, OP_LD, OP_ST, OP_IMM, OP_R, OP_SYS};
        w = $urandom;
        w[6:0]   = ops[$urandom_range(0, 9)];
        w[11:7]  = 5'($urandom_range(0, 7));
        w[19:15] = 5'($urandom_range(0, 7));
        w[24:20] = 5'($urandom_range(0, 7));
        return w;
    endfunction

    initial begin
        logic [31:0] s0;
        int k;
        bit found;
        foreach (m_known[i]) m_known[i] = 0;
        bus.in_valid = 0; bus.in_pc = '0; bus.in_instr = '0; bus.flush = 0;
        bus.wb_we = 0; bus.wb_addr = '0; bus.wb_data = '0; bus.out_ready = 1;

        repeat (3) @(posedge clk);
        #2;
        chk("rst out_valid", bus.out_valid, 0);
        chk("rst in_ready", bus.in_ready, 1);
        chk("rst stall_cnt", bus.stall_cnt, 0);
        chk("rst out_pc", bus.out_pc, 0);
        chk("rst out_instr", bus.out_instr, 0);
        chk("rst out_rd/we/ld", {bus.out_rd, bus.out_rd_we, bus.out_is_load}, 0);
        chk("rst out_rs", {bus.out_rs1_data, bus.out_rs2_data}, 0);
        reset = 0;

        for (int r = 1; r < 32; r++) begin
            bus.wb_we = 1; bus.wb_addr = 5'(r); bus.wb_data = $urandom;
            tick();
        end
        idle(2);

        // single ADDI: one-cycle enqueue-to-issue
        enq(32'h100, I_ADDI1);
        chk("addi not yet", bus.out_valid, 0);
        tick();
        chk("addi valid", bus.out_valid, 1);
        chk("addi pc", bus.out_pc, 32'h100);
        chk("addi rd", bus.out_rd, 1);
        chk("addi rd_we", bus.out_rd_we, 1);
        chk("addi stall", bus.stall_cnt, 0);
        idle(2);

        // load-use: LL stall cycles, ADD appears LL+1 edges after the LW issue edge
        s0 = bus.stall_cnt;
        enq(32'h200, I_LW5);
        enq(32'h204, I_ADD6);
        chk("lw issued", bus.out_instr, I_LW5);
        found = 0; k = 0;
        while (!found && k < 20) begin
            tick(); k++;
            if (bus.out_valid && bus.out_instr == I_ADD6) found = 1;
        end
        chk("add found", found, 1);
        chk("add issue gap", k, LL + 1);
        chk("load-use stalls", bus.stall_cnt - s0, LL);
        idle(2);

        // back-pressure: hold first, fill queue, drain in order
        bus.out_ready = 0;
        enq(32'h300, 32'h0010_0513); // addi x10,x0,1
        enq(32'h304, 32'h0020_0593); // addi x11,x0,2
        enq(32'h308, 32'h0030_0613); // addi x12,x0,3
        chk("bp in_ready", bus.in_ready, 0);
        chk("bp head held", bus.out_pc, 32'h300);
        repeat (3) tick();
        chk("bp stable pc", bus.out_pc, 32'h300);
        chk("bp stable valid", bus.out_valid, 1);
        bus.out_ready = 1;
        tick();
        chk("drain 2", bus.out_pc, 32'h304);
        tick();
        chk("drain 3", bus.out_pc, 32'h308);
        tick();
        chk("drain done", bus.out_valid, 0);
        idle(1);

        // write-through read and x0
        enq(32'h400, I_ADD8);
        bus.wb_we = 1; bus.wb_addr = 7; bus.wb_data = 32'hDEAD_BEEF;
        tick();
        bus.wb_we = 0;
        chk("bypass rs1", bus.out_rs1_data, 32'hDEAD_BEEF);
        bus.wb_we = 1; bus.wb_addr = 0; bus.wb_data = 32'h1234_5678;
        enq(32'h404, I_ADD9);
        tick();
        bus.wb_we = 0;
        chk("x0 rs1", bus.out_rs1_data, 0);
        chk("x0 rs2", bus.out_rs2_data, 0);
        idle(2);

        // flush kills queue, issue reg and scoreboard
        enq(32'h500, I_LW3);
        enq(32'h504, I_SUB4);
        bus.flush = 1;
        tick();
        bus.flush = 0;
        chk("flush out_valid", bus.out_valid, 0);
        chk("flush in_ready", bus.in_ready, 1);
        s0 = bus.stall_cnt;
        enq(32'h508, I_SUB4);
        tick();
        chk("post-flush issue", bus.out_instr, I_SUB4);
        chk("post-flush valid", bus.out_valid, 1);
        chk("post-flush no stall", bus.stall_cnt, s0);
        idle(2);

        // saturation of the stall counter
        force dut.stall_q = 32'hFFFF_FFFE;
        m_stall = 32'hFFFF_FFFE;
        #1;
        release dut.stall_q;
        enq(32'h600, I_LW5);
        enq(32'h604, I_ADD6);
        repeat (4) tick();
        chk("stall saturate", bus.stall_cnt, 32'hFFFF_FFFF);
        enq(32'h608, I_LW5);
        enq(32'h60C, I_ADD6);
        repeat (4) tick();
        chk("stall stays sat", bus.stall_cnt, 32'hFFFF_FFFF);
        idle(2);

        // randomized traffic with one asynchronous reset in the middle
        for (int i = 0; i < 3000; i++) begin
            bus.in_valid  = ($urandom_range(0, 9) < 6);
            bus.in_pc     = $urandom & ~32'h3;
            bus.in_instr  = rand_instr();
            bus.out_ready = ($urandom_range(0, 9) < 7);
            bus.flush     = ($urandom_range(0, 49) == 0);
            bus.wb_we     = $urandom_range(0, 1);
            bus.wb_addr   = 5'($urandom_range(0, 31));
            bus.wb_data   = $urandom;
            if (i == 1500) begin
                reset = 1;
                #1;
                chk("async rst valid", bus.out_valid, 0);
                chk("async rst in_ready", bus.in_ready, 1);
                chk("async rst stall", bus.stall_cnt, 0);
                tick();
                reset = 0;
            end
            tick();
        end
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
